xor2_kernel_sched: RTL and testbench
====================================

Name: xor2_kernel_sched

Overview:
- Time-shares one combinational XOR-of-NAND-products kernel among NREQ requesters. The kernel takes four 8-bit operands a0/b0/a1/b1 and returns a 7-bit y.
- Round-robin arbitration, registered operand launch and multicycle settle window give the kernel a fixed SETTLE_CYC-cycle timing budget.
- Registered response with valid/ready handshake and requester ID.
- Sits between the operand producers and the kernel instance; the kernel is driven via kern_* ports.

Parameters:
- NREQ, 4, number of requesters (2..8).
- SETTLE_CYC, 2, cycles operands are held stable before kern_y is captured (1..15).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept, at most one bit high (one-hot or zero).
- req_opnd  in  NREQ*32  requester i at bits [32i+31:32i], packed {a0,b0,a1,b1}, a0 in the MSB byte.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_y  out  7  captured kernel result.
- rsp_id  out  IDW  index of the requester that owns rsp_y; IDW = max(1, clog2(NREQ)).
- kern_a0, kern_b0, kern_a1, kern_b1  out  8 each  registered operands to the kernel.
- kern_y  in  7  kernel combinational result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, all outputs 0, rr pointer=0, settle counter=0.
- State IDLE:
  - req_ready is driven combinationally: the one-hot grant of the round-robin arbiter over req_valid. Search starts at rr pointer; the pointer holds the index after the last granted requester.
  - On req_valid[g]&req_ready[g]: latch req_opnd slice g into the kern_* registers, latch g into id_q, load cnt=SETTLE_CYC-1, pointer=(g+1) mod NREQ, go SETTLE.
  - No valid request: stay IDLE, req_ready=0.
- State SETTLE:
  - req_ready=0. kern_* are stable. cnt decrements each cycle.
  - When cnt==0: rsp_y<=kern_y, rsp_id<=id_q, rsp_valid<=1, go RESP.
- State RESP:
  - Holds rsp_valid/rsp_y/rsp_id stable until rsp_ready. On rsp_valid&rsp_ready: rsp_valid<=0, go IDLE.
  - No new grant is issued in the handshake cycle.
- Latency: a grant at edge t gives rsp_valid high after edge t+SETTLE_CYC.
- Throughput: with rsp_ready tied high, a new grant is possible SETTLE_CYC+2 cycles after the previous one.
- kern_* registers hold their last value in IDLE and RESP. They change only on a grant, so no glitches reach the kernel outside a launch.
- Fairness: a requester holding req_valid waits at most NREQ-1 other grants.
- Requester drops req_valid while not granted: no effect. req_opnd is sampled only in the grant cycle.
- Reset mid-SETTLE or mid-RESP: the transaction is dropped and all outputs return to 0 immediately. No response is produced.
- NREQ=1: arbiter degenerates to req_ready=req_valid in IDLE; rsp_id=0.

Optional Feature:
- Macro XOR2_SCHED_STATS_EN.
- When defined:
  - Extra outputs stat_ops (16 bits): saturating count of completed response handshakes.
  - stat_stall (16 bits): saturating count of RESP cycles with rsp_ready=0.
  - Both counters reset to 0 and saturate at 16'hFFFF.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package xor2_sched_pkg:
  - OPW=8, YW=7, OPND_W=4*OPW.
  - State enum {IDLE, SETTLE, RESP}.
  - Function idw(n) for ID width.
- Sub-module rr_arbiter (parameter N):
  - Inputs req[N], ptr; output gnt[N] one-hot, plus gnt_idx.
  - Purely combinational. The pointer register lives in xor2_kernel_sched.

Test Plan:
1. Reset then single request: NREQ=4, SETTLE_CYC=2, req_valid=4'b0100, req_opnd[2]=32'h11223344, kern_y stub=7'h5A.
   - req_ready=4'b0100 for one cycle; kern_a0=8'h11, kern_b0=8'h22, kern_a1=8'h33, kern_b1=8'h44.
   - Two edges after the grant: rsp_valid=1, rsp_y=7'h5A, rsp_id=2.
2. All four requesters valid continuously, rsp_ready=1: grants in order 0,1,2,3,0; a new grant every 4 cycles; rsp_id sequence 0,1,2,3,0.
3. Backpressure: rsp_ready=0 for 5 cycles in RESP.
   - rsp_valid/rsp_y/rsp_id are stable; req_ready stays 0.
   - kern_* unchanged when the kern_y stub changes.
   - After rsp_ready=1: back to IDLE.
4. Async reset pulse mid-SETTLE: all outputs 0 without a clock edge; after release, no rsp_valid until a new request.
5. SETTLE_CYC=5: the kern_y stub changes from 7'h01 to 7'h7F two cycles before capture; captured rsp_y=7'h7F, first valid 5 edges after the grant.
6. With XOR2_SCHED_STATS_EN: 3 transactions, each stalled 2 cycles -> stat_ops=3, stat_stall=6.

Source files
------------

// File: rtl/xor2_sched_pkg.sv
// Shared widths, FSM encoding and ID-width helper for the XOR2 kernel scheduler.
package xor2_sched_pkg;
    localparam int OPW    = 8;
    localparam int YW     = 7;
    localparam int OPND_W = 4 * OPW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_e;

    function automatic int idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/xor2_kernel_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
module rr_arbiter
    import xor2_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idw(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);
    logic          found;
    logic [IW:0]   pos;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        pos     = '0;
        for (int i = 0; i < N; i++) begin
            // One extra bit so ptr+i cannot overflow before the wrap.
            pos = {1'b0, ptr} + (IW+1)'(i);
            if (pos >= (IW+1)'(N)) begin
                pos = pos - (IW+1)'(N);
            end
            if (!found && req[pos[IW-1:0]]) begin
                gnt[pos[IW-1:0]] = 1'b1;
                gnt_idx          = pos[IW-1:0];
                found            = 1'b1;
            end
        end
    end
endmodule

// File: rtl/xor2_kernel_sched.sv
// Time-shares one XOR-of-NAND kernel among NREQ requesters with a fixed settle window.
// Optional statistics counters are built when XOR2_SCHED_STATS_EN is defined.
module xor2_kernel_sched
    import xor2_sched_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int SETTLE_CYC = 2,
    parameter int IDW        = idw(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*OPND_W-1:0] req_opnd,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [YW-1:0]          rsp_y,
    output logic [IDW-1:0]         rsp_id,
    output logic [OPW-1:0]         kern_a0,
    output logic [OPW-1:0]         kern_b0,
    output logic [OPW-1:0]         kern_a1,
    output logic [OPW-1:0]         kern_b1,
    input  logic [YW-1:0]          kern_y,
    output logic                   busy
`ifdef XOR2_SCHED_STATS_EN
    ,
    output logic [15:0]            stat_ops,
    output logic [15:0]            stat_stall
`endif
);
    localparam int CW = 4;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IDW-1:0]      ptr_q, ptr_d;
    logic [IDW-1:0]      id_q, id_d;
    logic [IDW-1:0]      rsp_id_q, rsp_id_d;
    logic [OPND_W-1:0]   kern_q, kern_d;
    logic [YW-1:0]       rsp_y_q, rsp_y_d;
    logic                rsp_valid_q, rsp_valid_d;

    logic [NREQ-1:0]     gnt;
    logic [IDW-1:0]      gnt_idx;
    logic [OPND_W-1:0]   sel_opnd;
    logic [IDW:0]        ptr_nxt;

    rr_arbiter #(.N(NREQ), .IW(IDW)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Grants are offered only while idle and never during reset.
    assign req_ready = (state_q == IDLE && !rst) ? gnt : '0;

    always_comb begin
        sel_opnd = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_opnd = req_opnd[i*OPND_W +: OPND_W];
            end
        end
        ptr_nxt = {1'b0, gnt_idx} + (IDW+1)'(1);
        if (ptr_nxt >= (IDW+1)'(NREQ)) begin
            ptr_nxt = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        kern_d      = kern_q;
        rsp_y_d     = rsp_y_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            IDLE: begin
                if (|(req_valid & req_ready)) begin
                    kern_d  = sel_opnd;
                    id_d    = gnt_idx;
                    cnt_d   = CW'(SETTLE_CYC - 1);
                    ptr_d   = ptr_nxt[IDW-1:0];
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    rsp_y_d     = kern_y;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ptr_q       <= '0;
            id_q        <= '0;
            kern_q      <= '0;
            rsp_y_q     <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            kern_q      <= kern_d;
            rsp_y_q     <= rsp_y_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign {kern_a0, kern_b0, kern_a1, kern_b1} = kern_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);

`ifdef XOR2_SCHED_STATS_EN
    logic [15:0] ops_q, ops_d, stall_q, stall_d;

    always_comb begin
        ops_d   = ops_q;
        stall_d = stall_q;
        if (state_q == RESP && rsp_ready && ops_q != 16'hFFFF) begin
            ops_d = ops_q + 16'd1;
        end
        if (state_q == RESP && !rsp_ready && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops_q   <= '0;
            stall_q <= '0;
        end else begin
            ops_q   <= ops_d;
            stall_q <= stall_d;
        end
    end

    assign stat_ops   = ops_q;
    assign stat_stall = stall_q;
`endif
endmodule

// File: tb/tb_xor2_kernel_sched.sv
// Self-checking bench for xor2_kernel_sched: directed tables, corner sequences, random run vs model.
module tb_xor2_kernel_sched;
    localparam int N   = 4;
    localparam int SC  = 2;
    localparam int SC5 = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid, req_ready;
    logic [N*32-1:0] req_opnd;
    logic            rsp_valid, rsp_ready, busy;
    logic [6:0]      rsp_y, kern_y;
    logic [1:0]      rsp_id;
    logic [7:0]      kern_a0, kern_b0, kern_a1, kern_b1;
    logic            stub_const;
    logic [6:0]      stub_val;

    logic [N-1:0]    f_req_valid, f_req_ready;
    logic [N*32-1:0] f_req_opnd;
    logic            f_rsp_valid, f_rsp_ready, f_busy;
    logic [6:0]      f_rsp_y, f_kern_y;
    logic [1:0]      f_rsp_id;
    logic [7:0]      f_a0, f_b0, f_a1, f_b1;
`ifdef XOR2_SCHED_STATS_EN
    logic [15:0]     stat_ops, stat_stall, f_stat_ops, f_stat_stall;
`endif

    function automatic logic [6:0] kfun(input logic [31:0] o);
        logic [7:0] t;
        t = ~(o[31:24] & o[23:16]) ^ ~(o[15:8] & o[7:0]);
        return t[6:0];
    endfunction

    assign kern_y = stub_const ? stub_val : kfun({kern_a0, kern_b0, kern_a1, kern_b1});

    xor2_kernel_sched #(.NREQ(N), .SETTLE_CYC(SC)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_opnd(req_opnd), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_id(rsp_id), .kern_a0(kern_a0), .kern_b0(kern_b0),
        .kern_a1(kern_a1), .kern_b1(kern_b1), .kern_y(kern_y), .busy(busy)
`ifdef XOR2_SCHED_STATS_EN
        , .stat_ops(stat_ops), .stat_stall(stat_stall)
`endif
    );

    xor2_kernel_sched #(.NREQ(N), .SETTLE_CYC(SC5)) u_dut5 (
        .clk(clk), .rst(rst), .req_valid(f_req_valid), .req_ready(f_req_ready),
        .req_opnd(f_req_opnd), .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready),
        .rsp_y(f_rsp_y), .rsp_id(f_rsp_id), .kern_a0(f_a0), .kern_b0(f_b0),
        .kern_a1(f_a1), .kern_b1(f_b1), .kern_y(f_kern_y), .busy(f_busy)
`ifdef XOR2_SCHED_STATS_EN
        , .stat_ops(f_stat_ops), .stat_stall(f_stat_stall)
`endif
    );

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (!rsp_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_timeout"}, 32'(rsp_valid), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0; req_opnd = '0; rsp_ready = 1'b0;
        f_req_valid = '0; f_req_opnd = '0; f_rsp_ready = 1'b0;
        stub_const = 1'b1; stub_val = '0; f_kern_y = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Round-robin choice from the rule: first valid index at or after the pointer.
    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] opnd;
        logic [3:0]  exp_gnt;
        logic [1:0]  exp_id;
    } vec_t;
    vec_t vecs[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gid[5], gcyc[5], rid[5];
        int ng, nr, g, m_phase, m_left, m_ptr;
        logic [31:0] m_opnd, sl;
        logic [8:0]  e;
        logic [3:0]  exp_rdy;

        vecs[0] = '{4'b0100, 32'h11223344, 4'b0100, 2'd2};
        vecs[1] = '{4'b0011, 32'hA5A5F00F, 4'b0001, 2'd0};
        vecs[2] = '{4'b0011, 32'hFFFFFFFF, 4'b0010, 2'd1};
        vecs[3] = '{4'b1001, 32'h00000000, 4'b1000, 2'd3};
        vecs[4] = '{4'b1111, 32'h80FF7F01, 4'b0001, 2'd0};
        vecs[5] = '{4'b0001, 32'h12345678, 4'b0001, 2'd0};
        vecs[6] = '{4'b1100, 32'hDEADBEEF, 4'b0100, 2'd2};
        vecs[7] = '{4'b0110, 32'h0F0F3C3C, 4'b0010, 2'd1};

        // Reset, single request, then backpressure in RESP.
        do_reset();
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_y", 32'(rsp_y), 0);
        chk("rst_id", 32'(rsp_id), 0);
        chk("rst_kern", {kern_a0, kern_b0, kern_a1, kern_b1}, 0);
        chk("rst_busy", 32'(busy), 0);
        stub_val = 7'h5A;
        req_opnd[95:64] = 32'h11223344;
        req_valid = 4'b0100;
        #1 chk("t1_ready", 32'(req_ready), 32'h4);
        @(negedge clk);
        req_valid = '0;
        #1 chk("t1_ready_drop", 32'(req_ready), 0);
        chk("t1_kern", {kern_a0, kern_b0, kern_a1, kern_b1}, 32'h11223344);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_valid_t0", 32'(rsp_valid), 0);
        @(negedge clk);
        chk("t1_valid_t1", 32'(rsp_valid), 0);
        @(negedge clk);
        chk("t1_valid_t2", 32'(rsp_valid), 1);
        chk("t1_y", 32'(rsp_y), 32'h5A);
        chk("t1_id", 32'(rsp_id), 2);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            stub_val = 7'($urandom_range(0, 127));
            @(negedge clk);
            chk("t3_valid", 32'(rsp_valid), 1);
            chk("t3_y", 32'(rsp_y), 32'h5A);
            chk("t3_id", 32'(rsp_id), 2);
            chk("t3_ready", 32'(req_ready), 0);
            chk("t3_kern", {kern_a0, kern_b0, kern_a1, kern_b1}, 32'h11223344);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t3_release_valid", 32'(rsp_valid), 0);
        chk("t3_release_busy", 32'(busy), 0);
        chk("t3_next_ptr", 32'(req_ready), 32'h8);
        req_valid = '0;
        rsp_ready = 1'b0;

        // All requesters valid, consumer always ready: round-robin throughput.
        do_reset();
        stub_const = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) req_opnd[i*32 +: 32] = $urandom();
        ng = 0; nr = 0;
        for (int c = 0; c < 60 && (ng < 5 || nr < 5); c++) begin
            #1;
            if (rsp_valid && nr < 5) begin rid[nr] = int'(rsp_id); nr++; end
            if (|req_ready && ng < 5) begin
                for (int i = 0; i < N; i++) if (req_ready[i]) gid[ng] = i;
                gcyc[ng] = c;
                ng++;
            end
            @(negedge clk);
        end
        chk("t2_grants", ng, 5);
        chk("t2_resps", nr, 5);
        for (int i = 0; i < 5; i++) begin
            if (i < ng) chk("t2_gid", gid[i], i % N);
            if (i < nr) chk("t2_rid", rid[i], i % N);
            if (i > 0 && i < ng) chk("t2_spacing", gcyc[i] - gcyc[i-1], SC + 2);
        end
        req_valid = '0;

        // Table of arbitration patterns with the pointer carried between entries.
        do_reset();
        stub_const = 1'b0;
        rsp_ready = 1'b1;
        foreach (vecs[v]) begin
            req_valid = vecs[v].valid;
            req_opnd  = {N{vecs[v].opnd}};
            #1 chk("tbl_ready", 32'(req_ready), 32'(vecs[v].exp_gnt));
            @(negedge clk);
            req_valid = '0;
            chk("tbl_kern", {kern_a0, kern_b0, kern_a1, kern_b1}, vecs[v].opnd);
            wait_valid("tbl");
            chk("tbl_id", 32'(rsp_id), 32'(vecs[v].exp_id));
            chk("tbl_y", 32'(rsp_y), 32'(kfun(vecs[v].opnd)));
            @(negedge clk);
            chk("tbl_idle", 32'(busy), 0);
        end

        // Async reset in the middle of SETTLE drops the transaction.
        do_reset();
        stub_val = 7'h33;
        req_valid = 4'b0001;
        req_opnd = {N{32'hCAFEF00D}};
        @(negedge clk);
        req_valid = '0;
        chk("t4_busy_pre", 32'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("t4_busy", 32'(busy), 0);
        chk("t4_kern", {kern_a0, kern_b0, kern_a1, kern_b1}, 0);
        chk("t4_valid", 32'(rsp_valid), 0);
        chk("t4_ready", 32'(req_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t4_no_rsp", 32'(rsp_valid), 0);
        end

        // SETTLE_CYC=5: late kern_y change is captured, latency is 5 edges.
        do_reset();
        f_kern_y = 7'h01;
        f_rsp_ready = 1'b1;
        f_req_opnd = {N{32'h01020304}};
        f_req_valid = 4'b0010;
        #1 chk("t5_ready", 32'(f_req_ready), 32'h2);
        @(negedge clk);
        f_req_valid = '0;
        for (int k = 1; k <= SC5; k++) begin
            @(negedge clk);
            chk("t5_valid", 32'(f_rsp_valid), (k == SC5) ? 1 : 0);
            if (k == 3) f_kern_y = 7'h7F;
        end
        chk("t5_y", 32'(f_rsp_y), 32'h7F);
        chk("t5_id", 32'(f_rsp_id), 1);

`ifdef XOR2_SCHED_STATS_EN
        do_reset();
        chk("t6_ops_rst", 32'(stat_ops), 0);
        chk("t6_stall_rst", 32'(stat_stall), 0);
        for (int t = 0; t < 3; t++) begin
            req_valid = 4'b0001;
            @(negedge clk);
            req_valid = '0;
            wait_valid("t6");
            repeat (2) @(negedge clk);
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
        chk("t6_ops", 32'(stat_ops), 3);
        chk("t6_stall", 32'(stat_stall), 6);
`endif

        // Random traffic against a latency/round-robin model with an expected queue.
        do_reset();
        stub_const = 1'b0;
        m_phase = 0; m_left = 0; m_ptr = 0; m_opnd = '0;
        exp_q.delete();
        for (int c = 0; c < 600; c++) begin
            req_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) req_opnd[i*32 +: 32] = $urandom();
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            g = (m_phase == 0) ? rr_pick(req_valid, m_ptr) : -1;
            exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
            chk("rnd_ready", 32'(req_ready), 32'(exp_rdy));
            chk("rnd_valid", 32'(rsp_valid), (m_phase == 2) ? 1 : 0);
            chk("rnd_busy", 32'(busy), (m_phase != 0) ? 1 : 0);
            if (m_phase != 0) chk("rnd_kern", {kern_a0, kern_b0, kern_a1, kern_b1}, m_opnd);
            case (m_phase)
                0: if (g >= 0) begin
                    sl = req_opnd[g*32 +: 32];
                    m_opnd = sl;
                    exp_q.push_back({2'(g), kfun(sl)});
                    m_ptr = (g + 1) % N;
                    m_left = SC;
                    m_phase = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                default: if (rsp_ready) begin
                    chk("rnd_q_empty", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("rnd_id", 32'(rsp_id), 32'(e[8:7]));
                        chk("rnd_y", 32'(rsp_y), 32'(e[6:0]));
                    end
                    m_phase = 0;
                end
            endcase
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
